// File: rtl/tqvp_sample_player.sv
// tqvp_sample_player: TinyQV byte peripheral that plays CPU-supplied 8-bit
// samples out on uo_out at a programmable rate. Samples are queued in a small
// FIFO; an optional 2x interpolation mode inserts the midpoint between each
// pair of consecutive samples. Status flags allow the CPU to poll for room.
module tqvp_sample_player #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Playback state
  logic [7:0]  out_reg;
  logic [7:0]  last_reg;
  logic [7:0]  pend_reg;
  logic        phase_reg;

  // Control / status registers
  logic [15:0] div_reg;
  logic        en_reg;
  logic        interp_reg;
  logic        underflow_reg;
  logic        overflow_reg;
  logic [15:0] tick_cnt_reg;

  // Decoded bus strobes
  logic push_req;
  logic div_lo_wr;
  logic div_hi_wr;
  logic ctrl_wr;
  logic status_wr;
  logic flush;

  // Datapath helpers
  logic       tick;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop_slot;
  logic       pop;
  logic       push_ok;
  logic       underflow_set;
  logic       overflow_set;
  logic [7:0] head;
  logic [8:0] sum9;
  logic [7:0] mid;
  logic [3:0] count_field;

  // The input PMOD is not used by this block.
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, 1'b0};

  assign push_req  = data_write && (address == 4'h0);
  assign div_lo_wr = data_write && (address == 4'h1);
  assign div_hi_wr = data_write && (address == 4'h2);
  assign ctrl_wr   = data_write && (address == 4'h3);
  assign status_wr = data_write && (address == 4'h4);
  assign flush     = ctrl_wr && data_in[2];

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(DEPTH));

  // A tick fires on the cycle the running counter has reached zero.
  assign tick = en_reg && (tick_cnt_reg == 16'h0000);

  // Ticks that want a new sample: every tick when not interpolating, only
  // the phase-0 ticks when interpolating (phase 1 replays PEND instead).
  assign pop_slot = tick && (!interp_reg || !phase_reg);
  assign pop      = pop_slot && !fifo_empty && !flush;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_ok       = push_req && (!fifo_full || pop);
  assign overflow_set  = push_req && !push_ok;
  assign underflow_set = pop_slot && fifo_empty;

  assign head = fifo_mem[rd_ptr_reg];
  assign sum9 = {1'b0, last_reg} + {1'b0, head};
  assign mid  = sum9[8:1];

  assign count_field = 4'(count_reg);

  // Rate divider: held at DIV while disabled, counts down and reloads when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= 16'h0000;
    end else if (!en_reg || (tick_cnt_reg == 16'h0000)) begin
      tick_cnt_reg <= div_reg;
    end else begin
      tick_cnt_reg <= tick_cnt_reg - 16'd1;
    end
  end

  // Sample storage write port; flushed pushes are discarded.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      fifo_mem[wr_ptr_reg] <= data_in;
    end
  end

  // FIFO pointers and occupancy; flush wins over a concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push_ok && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push_ok) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // Output sample update on each tick, direct or interpolated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= 8'h00;
      last_reg <= 8'h00;
      pend_reg <= 8'h00;
    end else if (tick) begin
      if (interp_reg && phase_reg) begin
        out_reg  <= pend_reg;
        last_reg <= pend_reg;
      end else if (pop) begin
        if (interp_reg) begin
          out_reg  <= mid;
          pend_reg <= head;
        end else begin
          out_reg  <= head;
          last_reg <= head;
        end
      end
    end
  end

  // Interpolation phase: 0 = next tick emits a midpoint, 1 = next tick emits PEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= 1'b0;
    end else if (flush) begin
      phase_reg <= 1'b0;
    end else if (tick && interp_reg) begin
      if (phase_reg) begin
        phase_reg <= 1'b0;
      end else if (pop) begin
        phase_reg <= 1'b1;
      end
    end
  end

  // CPU-writable control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg    <= 16'h0000;
      en_reg     <= 1'b0;
      interp_reg <= 1'b0;
    end else begin
      if (div_lo_wr) begin
        div_reg[7:0] <= data_in;
      end
      if (div_hi_wr) begin
        div_reg[15:8] <= data_in;
      end
      if (ctrl_wr) begin
        en_reg     <= data_in[0];
        interp_reg <= data_in[1];
      end
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (underflow_set) begin
        underflow_reg <= 1'b1;
      end else if (status_wr && data_in[2]) begin
        underflow_reg <= 1'b0;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (status_wr && data_in[3]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Register read mux, combinational from address.
  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = out_reg;
      4'h1:    data_out = div_reg[7:0];
      4'h2:    data_out = div_reg[15:8];
      4'h3:    data_out = {6'b000000, interp_reg, en_reg};
      4'h4:    data_out = {count_field, overflow_reg, underflow_reg, fifo_full, fifo_empty};
      default: data_out = 8'h00;
    endcase
  end

  assign uo_out = out_reg;

endmodule

// File: tb/tb_tqvp_sample_player.sv
// Testbench for tqvp_sample_player: a register-access vector table plus
// hand-written playback sequences checked through an output scoreboard that
// records the expected sample value and the cycle on which it must appear.
module tb_tqvp_sample_player;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  tqvp_sample_player #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [7:0] val;
    int         at;
  } sb_t;
  sb_t exp_q[$];
  logic sb_on = 1'b0;

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    $display("wr addr=%0h data=%02h cycle=%0d", a, d, cyc);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(posedge clk);
    #1;
    data_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp);
    address = a;
    #1;
    $display("rd addr=%0h data=%02h cycle=%0d", a, data_out, cyc);
    check(name, data_out, exp);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input logic [7:0] v, input int at);
    sb_t e;
    e.val = v;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  // Output monitor: every change of uo_out must match the next scoreboard entry.
  initial begin
    logic [7:0] prev_out;
    sb_t e;
    prev_out = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (sb_on && (uo_out !== prev_out)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got uo_out 0x%02h, required it to hold 0x%02h (cycle %0d)",
                   uo_out, prev_out, cyc);
        end else begin
          e = exp_q.pop_front();
          $display("out uo_out=%02h cycle=%0d", uo_out, cyc);
          check("sb_value", uo_out, e.val);
          check("sb_cycle", cyc, e.at);
        end
      end
      prev_out = uo_out;
    end
  end

  initial begin
    int e;
    ui_in      = 8'h00;
    address    = 4'h0;
    data_write = 1'b0;
    data_in    = 8'h00;
    rst_n      = 1'b0;

    vecs[0]  = '{4'h0, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{4'h1, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{4'h2, 1'b0, 8'h00, 8'h00};
    vecs[3]  = '{4'h3, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{4'h4, 1'b0, 8'h00, 8'h01};
    vecs[5]  = '{4'h5, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{4'hF, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{4'h1, 1'b1, 8'hA5, 8'h00};
    vecs[8]  = '{4'h2, 1'b1, 8'h3C, 8'h00};
    vecs[9]  = '{4'h1, 1'b0, 8'h00, 8'hA5};
    vecs[10] = '{4'h2, 1'b0, 8'h00, 8'h3C};
    vecs[11] = '{4'h3, 1'b1, 8'h06, 8'h00};
    vecs[12] = '{4'h3, 1'b0, 8'h00, 8'h02};
    vecs[13] = '{4'h4, 1'b0, 8'h00, 8'h01};
    vecs[14] = '{4'h3, 1'b1, 8'h00, 8'h00};
    vecs[15] = '{4'h3, 1'b0, 8'h00, 8'h00};
    vecs[16] = '{4'h5, 1'b1, 8'hFF, 8'h00};
    vecs[17] = '{4'h5, 1'b0, 8'h00, 8'h00};
    vecs[18] = '{4'h1, 1'b1, 8'h03, 8'h00};
    vecs[19] = '{4'h2, 1'b1, 8'h00, 8'h00};
    vecs[20] = '{4'h2, 1'b0, 8'h00, 8'h00};
    vecs[21] = '{4'h1, 1'b0, 8'h00, 8'h03};
    vecs[22] = '{4'h0, 1'b0, 8'h00, 8'h00};
    vecs[23] = '{4'h4, 1'b0, 8'h00, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    check("reset_uo_out", uo_out, 32'h00);
    rst_n = 1'b1;
    sb_on = 1'b1;

    // Register map table; leaves DIV = 3, EN = 0.
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else rd($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Plain playback at DIV=3, then underflow once the FIFO runs dry.
    wr(4'h0, 8'h10);
    wr(4'h0, 8'h20);
    wr(4'h0, 8'h30);
    wr(4'h3, 8'h01);
    e = cyc;
    expect_out(8'h10, e + 4);
    expect_out(8'h20, e + 8);
    expect_out(8'h30, e + 12);
    wait_until(e + 13);
    check("play_drained", exp_q.size(), 0);
    wait_until(e + 16);
    rd("underflow_status", 4'h4, 8'h05);
    check("underflow_hold", uo_out, 32'h30);
    wr(4'h3, 8'h00);
    wr(4'h4, 8'h04);
    rd("underflow_clear", 4'h4, 8'h01);

    // Overflow: nine pushes into an 8-entry FIFO while disabled.
    for (int i = 1; i <= 9; i++) wr(4'h0, 8'(i));
    rd("overflow_status", 4'h4, 8'h8A);
    wr(4'h4, 8'h08);
    rd("overflow_clear", 4'h4, 8'h82);

    // Full FIFO with a push landing on the tick cycle: accepted, no overflow.
    wr(4'h3, 8'h01);
    e = cyc;
    expect_out(8'h01, e + 4);
    wait_until(e + 3);
    wr(4'h0, 8'hAA);
    wr(4'h3, 8'h00);
    rd("full_push_on_tick", 4'h4, 8'h82);

    // Flush mid-playback with five samples queued.
    wr(4'h3, 8'h01);
    e = cyc;
    expect_out(8'h02, e + 4);
    expect_out(8'h03, e + 8);
    expect_out(8'h04, e + 12);
    wait_until(e + 12);
    rd("pre_flush_count", 4'h4, 8'h50);
    wr(4'h3, 8'h05);
    rd("post_flush_status", 4'h4, 8'h01);
    check("flush_keeps_out", uo_out, 32'h04);
    check("flush_drained", exp_q.size(), 0);

    // Push into an empty FIFO while playing, then reset mid-playback.
    wr(4'h0, 8'h11);
    wr(4'h0, 8'h22);
    expect_out(8'h11, e + 16);
    wait_until(e + 17);
    check("refill_out", uo_out, 32'h11);
    rd("refill_status", 4'h4, 8'h10);
    sb_on = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out", uo_out, 32'h00);
    rd("async_reset_status", 4'h4, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_on = 1'b1;

    // Interpolated playback at DIV=0 from LAST=0.
    wr(4'h0, 8'h40);
    wr(4'h0, 8'hFF);
    wr(4'h3, 8'h03);
    e = cyc;
    expect_out(8'h20, e + 1);
    expect_out(8'h40, e + 2);
    expect_out(8'h9F, e + 3);
    expect_out(8'hFF, e + 4);
    wait_until(e + 5);
    rd("interp_underflow", 4'h4, 8'h05);
    wait_until(e + 6);
    check("interp_drained", exp_q.size(), 0);
    check("interp_hold", uo_out, 32'hFF);
    wr(4'h3, 8'h00);

    sb_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
